fifo_read_drainer: RTL and testbench

Read-side consumer for the async FIFO. It runs in the read clock domain and drives `read_en` against `fifo_empty`. It absorbs the FIFO's one-cycle read latency, presents popped words as a valid/ready stream to downstream logic and counts pops. An optional checker verifies that the data is an incrementing sequence.

---
 rtl/fifo_read_drainer.sv | 135 +++++++++++++
 tb/tb_fifo_read_drainer.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_read_drainer.sv
// fifo_read_drainer: read-side consumer for the async FIFO.
// Pops into a 3-entry skid buffer and presents a valid/ready stream.
module fifo_read_drainer #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             rd_clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             chk_en,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] fifo_data,
    output logic             read_en,
    output logic [WIDTH-1:0] m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             busy,
    output logic [CNT_W-1:0] pop_count,
    output logic             seq_err
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FLUSH
    } state_t;

    state_t           state;
    logic [1:0]       occ;
    logic [1:0]       occ_nxt;
    logic             inflight;
    logic [2:0]       fill;
    logic             cap;
    logic             acc;
    logic [WIDTH-1:0] mem     [3];
    logic [WIDTH-1:0] mem_nxt [3];
    logic             first_seen;
    logic [WIDTH-1:0] exp_q;

    // The word popped last cycle is on fifo_data now
    assign cap  = inflight;
    assign acc  = m_valid & m_ready;
    assign fill = {1'b0, occ} + {2'b00, inflight};

    // Only registers and inputs: no path from m_ready
    assign read_en = rst_n & enable & ~fifo_empty
                   & (state == RUN) & (fill < 3'd3);

    assign m_data = mem[0];
    assign busy   = (state != IDLE) | (occ != 2'd0) | inflight;

    // Next buffer contents: shift out the head, then append the capture
    always_comb begin
        mem_nxt = mem;
        occ_nxt = occ;
        if (acc) begin
            mem_nxt[0] = mem[1];
            mem_nxt[1] = mem[2];
            occ_nxt    = occ - 2'd1;
        end
        if (cap) begin
            case (occ_nxt)
                2'd0:    mem_nxt[0] = fifo_data;
                2'd1:    mem_nxt[1] = fifo_data;
                2'd2:    mem_nxt[2] = fifo_data;
                default: ;
            endcase
            occ_nxt = occ_nxt + 2'd1;
        end
    end

    // Skid buffer, occupancy and the one-deep in-flight marker
    always_ff @(posedge rd_clk) begin
        if (!rst_n) begin
            occ      <= 2'd0;
            inflight <= 1'b0;
            m_valid  <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                mem[i] <= '0;
            end
        end else begin
            occ      <= occ_nxt;
            inflight <= read_en;
            m_valid  <= (occ_nxt != 2'd0);
            mem      <= mem_nxt;
        end
    end

    // Control FSM: RUN pops, FLUSH drains without popping
    always_ff @(posedge rd_clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (enable) state <= RUN;
                end
                RUN: begin
                    if (!enable) begin
                        if (occ != 2'd0 || inflight) state <= FLUSH;
                        else                         state <= IDLE;
                    end
                end
                FLUSH: begin
                    if (enable)                         state <= RUN;
                    else if (occ == 2'd0 && !inflight) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Saturating pop counter
    always_ff @(posedge rd_clk) begin
        if (!rst_n) begin
            pop_count <= '0;
        end else if (read_en && pop_count != {CNT_W{1'b1}}) begin
            pop_count <= pop_count + CNT_W'(1);
        end
    end

    // Incrementing-sequence checker on accepted beats
    always_ff @(posedge rd_clk) begin
        if (!rst_n) begin
            first_seen <= 1'b0;
            exp_q      <= '0;
            seq_err    <= 1'b0;
        end else if (chk_en && acc) begin
            first_seen <= 1'b1;
            exp_q      <= m_data + WIDTH'(1);
            if (first_seen && m_data != exp_q) seq_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fifo_read_drainer.sv
// tb_fifo_read_drainer: directed bench with a behavioural FIFO model.
// Cycle tables cover backpressure, flush and mid-stream reset.
module tb_fifo_read_drainer;

    logic        rd_clk;
    logic        rst_n;
    logic        enable;
    logic        chk_en;
    logic        fifo_empty;
    logic [7:0]  fifo_data;
    logic        read_en;
    logic [7:0]  m_data;
    logic        m_valid;
    logic        m_ready;
    logic        busy;
    logic [15:0] pop_count;
    logic        seq_err;

    int nerr = 0;
    int nchk = 0;

    logic [7:0] mem [0:255];
    int rp = 0;
    int wc = 0;

    typedef struct {
        bit         r;
        bit         e;
        bit         y;
        bit         re;
        bit         v;
        logic [7:0] d;
        bit         b;
        int         pc;
    } vec_t;

    vec_t tv[$];

    fifo_read_drainer #(.WIDTH(8), .CNT_W(16)) dut (
        .rd_clk     (rd_clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .chk_en     (chk_en),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .read_en    (read_en),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .busy       (busy),
        .pop_count  (pop_count),
        .seq_err    (seq_err)
    );

    initial rd_clk = 1'b0;
    always #5 rd_clk = ~rd_clk;

    assign fifo_empty = (rp == wc);

    // FIFO model: one-cycle read latency
    always @(posedge rd_clk) begin
        if (read_en && !fifo_empty) begin
            fifo_data <= mem[rp];
            rp <= rp + 1;
        end
    end

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic load(logic [7:0] first, int n);
        for (int i = 0; i < n; i++) begin
            mem[wc] = first + 8'(i);
            wc++;
        end
    endtask

    function automatic void add(bit r, bit e, bit y, bit re, bit v,
                                logic [7:0] d, bit b, int pc);
        vec_t t;
        t = '{r, e, y, re, v, d, b, pc};
        tv.push_back(t);
    endfunction

    task automatic do_reset();
        @(negedge rd_clk);
        rst_n   = 1'b0;
        enable  = 1'b0;
        m_ready = 1'b0;
        @(negedge rd_clk);
    endtask

    task automatic run_rows(int a, int b);
        string nm;
        for (int i = a; i <= b; i++) begin
            @(negedge rd_clk);
            rst_n   = tv[i].r;
            enable  = tv[i].e;
            m_ready = tv[i].y;
            #1;
            nm = $sformatf("row%0d", i);
            chk({nm, " read_en"}, 32'(read_en), 32'(tv[i].re));
            chk({nm, " m_valid"}, 32'(m_valid), 32'(tv[i].v));
            if (tv[i].v)
                chk({nm, " m_data"}, 32'(m_data), 32'(tv[i].d));
            chk({nm, " busy"}, 32'(busy), 32'(tv[i].b));
            chk({nm, " pop_count"}, 32'(pop_count), 32'(tv[i].pc));
        end
    endtask

    initial begin
        logic [7:0] e4 [25];
        int nacc;

        // rows 0-18: backpressure then drain of 0x01..0x0A
        //  rst en rdy re  v  data  busy pc
        add(1, 1, 0, 0, 0, 8'h00, 0, 0);
        add(1, 1, 0, 1, 0, 8'h00, 1, 0);
        add(1, 1, 0, 1, 0, 8'h00, 1, 1);
        add(1, 1, 0, 1, 1, 8'h01, 1, 2);
        add(1, 1, 0, 0, 1, 8'h01, 1, 3);
        add(1, 1, 0, 0, 1, 8'h01, 1, 3);
        add(1, 1, 0, 0, 1, 8'h01, 1, 3);
        add(1, 1, 1, 0, 1, 8'h01, 1, 3);
        add(1, 1, 1, 1, 1, 8'h02, 1, 3);
        add(1, 1, 1, 1, 1, 8'h03, 1, 4);
        add(1, 1, 1, 1, 1, 8'h04, 1, 5);
        add(1, 1, 1, 1, 1, 8'h05, 1, 6);
        add(1, 1, 1, 1, 1, 8'h06, 1, 7);
        add(1, 1, 1, 1, 1, 8'h07, 1, 8);
        add(1, 1, 1, 1, 1, 8'h08, 1, 9);
        add(1, 1, 1, 0, 1, 8'h09, 1, 10);
        add(1, 1, 1, 0, 1, 8'h0A, 1, 10);
        add(1, 0, 1, 0, 0, 8'h00, 1, 10);
        add(1, 0, 1, 0, 0, 8'h00, 0, 10);
        // rows 19-28: enable dropped after 4 pops
        add(1, 1, 1, 0, 0, 8'h00, 0, 0);
        add(1, 1, 1, 1, 0, 8'h00, 1, 0);
        add(1, 1, 1, 1, 0, 8'h00, 1, 1);
        add(1, 1, 1, 1, 1, 8'h30, 1, 2);
        add(1, 1, 1, 1, 1, 8'h31, 1, 3);
        add(1, 0, 1, 0, 1, 8'h32, 1, 4);
        add(1, 0, 1, 0, 1, 8'h33, 1, 4);
        add(1, 0, 1, 0, 0, 8'h00, 1, 4);
        add(1, 0, 1, 0, 0, 8'h00, 0, 4);
        add(1, 0, 1, 0, 0, 8'h00, 0, 4);
        // rows 29-48: reset with a full buffer, then clean restart
        add(1, 1, 0, 0, 0, 8'h00, 0, 4);
        add(1, 1, 0, 1, 0, 8'h00, 1, 4);
        add(1, 1, 0, 1, 0, 8'h00, 1, 5);
        add(1, 1, 0, 1, 1, 8'h34, 1, 6);
        add(0, 1, 0, 0, 1, 8'h34, 1, 7);
        add(0, 1, 0, 0, 0, 8'h00, 0, 0);
        add(1, 1, 1, 0, 0, 8'h00, 0, 0);
        add(1, 1, 1, 1, 0, 8'h00, 1, 0);
        add(1, 1, 1, 1, 0, 8'h00, 1, 1);
        add(1, 1, 1, 1, 1, 8'h37, 1, 2);
        add(1, 1, 1, 1, 1, 8'h38, 1, 3);
        add(1, 1, 1, 1, 1, 8'h39, 1, 4);
        add(1, 1, 1, 1, 1, 8'h3A, 1, 5);
        add(1, 1, 1, 1, 1, 8'h3B, 1, 6);
        add(1, 1, 1, 1, 1, 8'h3C, 1, 7);
        add(1, 1, 1, 1, 1, 8'h3D, 1, 8);
        add(1, 1, 1, 0, 1, 8'h3E, 1, 9);
        add(1, 1, 1, 0, 1, 8'h3F, 1, 9);
        add(1, 0, 1, 0, 0, 8'h00, 1, 9);
        add(1, 0, 1, 0, 0, 8'h00, 0, 9);

        rst_n   = 1'b0;
        enable  = 1'b1;
        chk_en  = 1'b1;
        m_ready = 1'b1;
        load(8'h01, 10);

        // reset held with words available and enable high
        for (int c = 0; c < 2; c++) begin
            @(negedge rd_clk);
            #1;
            chk("rst read_en", 32'(read_en), 0);
            chk("rst m_valid", 32'(m_valid), 0);
            chk("rst pop_count", 32'(pop_count), 0);
            chk("rst seq_err", 32'(seq_err), 0);
            chk("rst busy", 32'(busy), 0);
        end

        // full-rate stream of 0x01..0x0A
        for (int c = 0; c < 15; c++) begin
            @(negedge rd_clk);
            rst_n = 1'b1;
            #1;
            chk($sformatf("stream c%0d read_en", c), 32'(read_en),
                32'(c >= 1 && c <= 10));
            if (c >= 3 && c <= 12) begin
                chk($sformatf("stream c%0d m_valid", c), 32'(m_valid), 1);
                chk($sformatf("stream c%0d m_data", c), 32'(m_data),
                    32'(c - 2));
            end else begin
                chk($sformatf("stream c%0d m_valid", c), 32'(m_valid), 0);
            end
        end
        chk("stream pop_count", 32'(pop_count), 10);
        chk("stream seq_err", 32'(seq_err), 0);

        // backpressure
        do_reset();
        load(8'h01, 10);
        run_rows(0, 18);
        chk("bp seq_err", 32'(seq_err), 0);

        // checker: wrap is legal, 0x05 after 0x01 is not
        do_reset();
        load(8'hFE, 4);
        load(8'h05, 21);
        for (int k = 0; k < 25; k++)
            e4[k] = (k < 4) ? 8'hFE + 8'(k) : 8'h05 + 8'(k - 4);
        nacc = 0;
        for (int c = 0; c < 32; c++) begin
            @(negedge rd_clk);
            rst_n   = 1'b1;
            enable  = 1'b1;
            m_ready = 1'b1;
            #1;
            chk($sformatf("seq c%0d seq_err", c), 32'(seq_err),
                32'(nacc >= 5));
            if (m_valid) begin
                if (nacc < 25)
                    chk($sformatf("seq beat%0d", nacc), 32'(m_data),
                        32'(e4[nacc]));
                nacc++;
            end
        end
        chk("seq beats", 32'(nacc), 25);
        chk("seq pop_count", 32'(pop_count), 25);
        chk("seq sticky", 32'(seq_err), 1);

        // flush after enable drop
        do_reset();
        load(8'h30, 6);
        run_rows(19, 28);

        // reset mid-stream, then restart at FIFO head
        load(8'h36, 10);
        run_rows(29, 48);
        chk("restart seq_err", 32'(seq_err), 0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
